// File: rtl/posit_pkg.sv
// Shared definitions for the posit command sequencer: opcodes, FSM encoding
// and the NaR constant helper.
package posit_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int POSIT_MAX_W = 64;

  // NaR is the sign bit alone; an exponent field at least as wide as the word
  // is not a valid posit format, so it yields all zeros instead.
  function automatic logic [POSIT_MAX_W-1:0] posit_nar(input int width, input int es_w);
    logic [POSIT_MAX_W-1:0] v;
    v = '0;
    if (es_w >= 0 && es_w < width) v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/posit_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapped pointers, occupancy counter.
module posit_cmd_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/posit_cmd_sequencer.sv
// Queues posit arithmetic commands, issues them one at a time to the posit
// core, and returns results (or NaR on div-by-zero / timeout) in order.
//
// state    | meaning
// ST_IDLE  | waiting for a queued command and a free output slot
// ST_ISSUE | command popped; start the core or short-circuit div-by-zero
// ST_WAIT  | core running; count cycles until done or timeout
module posit_cmd_sequencer
  import posit_pkg::*;
#(
  parameter int posit_width = 8,
  parameter int es          = 1,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_opcode,
  input  logic [posit_width-1:0] in_a,
  input  logic [posit_width-1:0] in_b,
  output logic                   core_start,
  output logic [1:0]             core_opcode,
  output logic [posit_width-1:0] core_a,
  output logic [posit_width-1:0] core_b,
  input  logic                   core_done,
  input  logic                   core_zero,
  input  logic [posit_width-1:0] core_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [posit_width-1:0] out_result,
  output logic                   out_zero,
  output logic [1:0]             out_opcode,
  output logic                   out_err,
  output logic                   busy
);

  localparam int CMD_W = 2 + 2 * posit_width;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [POSIT_MAX_W-1:0] NAR_FULL = posit_nar(posit_width, es);
  localparam logic [posit_width-1:0] NAR = NAR_FULL[posit_width-1:0];

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [1:0]             r_core_op;
  logic [posit_width-1:0] r_core_a;
  logic [posit_width-1:0] r_core_b;
  logic                   r_out_valid;
  logic [posit_width-1:0] r_out_result;
  logic                   r_out_zero;
  logic [1:0]             r_out_opcode;
  logic                   r_out_err;

  logic [CMD_W-1:0]       w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_start;
  logic                   w_load_core;
  logic                   w_load_nar;
  logic                   w_nar_err;
  logic                   w_div_zero;
  logic                   w_slot_free;

  assign w_push      = in_valid && !w_full;
  assign w_div_zero  = (r_core_op == OP_DIV) && (r_core_b == '0);
  assign w_slot_free = !r_out_valid || out_ready;

  posit_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({in_opcode, in_a, in_b}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_load_core = 1'b0;
    w_load_nar  = 1'b0;
    w_nar_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && w_slot_free) begin
          w_pop  = 1'b1;
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_div_zero) begin
          w_load_nar = 1'b1;
          w_next     = ST_IDLE;
        end else begin
          w_start = 1'b1;
          w_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          w_load_core = 1'b1;
          w_next      = ST_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_load_nar = 1'b1;
          w_nar_err  = 1'b1;
          w_next     = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Counter only advances in WAIT; any other state parks it at zero.
  always_ff @(posedge clk) begin
    if (!reset)                  r_cnt <= '0;
    else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
    else                         r_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_core_op <= '0;
      r_core_a  <= '0;
      r_core_b  <= '0;
    end else if (w_pop) begin
      {r_core_op, r_core_a, r_core_b} <= w_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_zero   <= 1'b0;
      r_out_opcode <= '0;
      r_out_err    <= 1'b0;
    end else if (w_load_core) begin
      r_out_valid  <= 1'b1;
      r_out_result <= core_result;
      r_out_zero   <= core_zero;
      r_out_opcode <= r_core_op;
      r_out_err    <= 1'b0;
    end else if (w_load_nar) begin
      r_out_valid  <= 1'b1;
      r_out_result <= NAR;
      r_out_zero   <= 1'b0;
      r_out_opcode <= r_core_op;
      r_out_err    <= w_nar_err;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready    = !w_full;
  assign core_start  = w_start;
  assign core_opcode = r_core_op;
  assign core_a      = r_core_a;
  assign core_b      = r_core_b;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_zero    = r_out_zero;
  assign out_opcode  = r_out_opcode;
  assign out_err     = r_out_err;
  assign busy        = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_posit_cmd_sequencer.sv
// Scoreboard bench for posit_cmd_sequencer with a behavioural stub core.
module tb_posit_cmd_sequencer;

  typedef struct packed {
    logic [7:0] res;
    logic       zero;
    logic [1:0] op;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [1:0] in_opcode;
  logic [7:0] in_a, in_b;
  logic       core_start;
  logic [1:0] core_opcode;
  logic [7:0] core_a, core_b;
  logic       core_done, core_zero;
  logic [7:0] core_result;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic       out_zero;
  logic [1:0] out_opcode;
  logic       out_err;
  logic       busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  int   n_starts = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   valid_cyc = 0;
  int   n_results = 0;

  int         stub_left  = -1;
  int         stub_delay = 5;
  logic       stub_hang  = 1'b0;
  logic       stub_echo  = 1'b0;
  logic [7:0] stub_res   = 8'h00;
  logic       stub_zero  = 1'b0;

  always #5 clk = ~clk;

  posit_cmd_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_a        (in_a),
    .in_b        (in_b),
    .core_start  (core_start),
    .core_opcode (core_opcode),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_done   (core_done),
    .core_zero   (core_zero),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_opcode  (out_opcode),
    .out_err     (out_err),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Stub posit core: raises done stub_delay+1 cycles after seeing core_start.
  always @(posedge clk) begin
    #1;
    core_done = 1'b0;
    if (stub_left == 0) begin
      core_done   = 1'b1;
      core_result = stub_echo ? core_a : stub_res;
      core_zero   = stub_zero;
      stub_left   = -1;
    end else if (stub_left > 0) begin
      stub_left = stub_left - 1;
    end
    if (core_start && !stub_hang) stub_left = stub_delay;
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (core_start) begin
          n_starts++;
          start_cyc = cyc;
        end
        if (out_valid && !prev_valid) valid_cyc = cyc;
        if (out_valid && out_ready) begin
          chk("scoreboard_has_entry", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("result_%0d", n_results), {out_result, out_zero, out_opcode, out_err}, e);
          end
          n_results++;
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) $display("FAIL push_timeout actual=in_ready_low required=accepted");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int t;
    logic seen;
    reset = 1'b0;
    in_valid = 1'b0; in_opcode = 2'b00; in_a = 8'h00; in_b = 8'h00;
    out_ready = 1'b1;
    core_done = 1'b0; core_zero = 1'b0; core_result = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fields", {out_result, out_zero, out_opcode, out_err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_cmd", {core_opcode, core_a, core_b}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Divide through the core.
    stub_res = 8'hC5; stub_zero = 1'b0; stub_delay = 5;
    s0 = n_starts;
    exp_q.push_back('{res: 8'hC5, zero: 1'b0, op: 2'b11, err: 1'b0});
    push(2'b11, 8'h22, 8'hB7);
    drain("div");
    chk("div_starts", n_starts - s0, 1);

    // Divide by zero short-circuits the core.
    s0 = n_starts;
    exp_q.push_back('{res: 8'h80, zero: 1'b0, op: 2'b11, err: 1'b0});
    push(2'b11, 8'h40, 8'h00);
    drain("divz");
    chk("divz_starts", n_starts - s0, 0);

    // Zero result from add.
    stub_res = 8'h00; stub_zero = 1'b1;
    s0 = n_starts;
    exp_q.push_back('{res: 8'h00, zero: 1'b1, op: 2'b00, err: 1'b0});
    push(2'b00, 8'h40, 8'hC0);
    drain("add_zero");
    chk("add_zero_starts", n_starts - s0, 1);

    // b=0 on a non-divide still goes through the core.
    stub_res = 8'h00; stub_zero = 1'b1;
    s0 = n_starts;
    exp_q.push_back('{res: 8'h00, zero: 1'b1, op: 2'b10, err: 1'b0});
    push(2'b10, 8'h40, 8'h00);
    drain("mul_b0");
    chk("mul_b0_starts", n_starts - s0, 1);

    // Backpressure: fill FIFO behind one in-flight command, then drain in order.
    stub_echo = 1'b1; stub_zero = 1'b0; stub_delay = 2;
    out_ready = 1'b0;
    exp_q.push_back('{res: 8'h11, zero: 1'b0, op: 2'b00, err: 1'b0});
    exp_q.push_back('{res: 8'h22, zero: 1'b0, op: 2'b01, err: 1'b0});
    exp_q.push_back('{res: 8'h33, zero: 1'b0, op: 2'b10, err: 1'b0});
    exp_q.push_back('{res: 8'h44, zero: 1'b0, op: 2'b11, err: 1'b0});
    exp_q.push_back('{res: 8'h55, zero: 1'b0, op: 2'b00, err: 1'b0});
    push(2'b00, 8'h11, 8'h01);
    push(2'b01, 8'h22, 8'h02);
    push(2'b10, 8'h33, 8'h03);
    push(2'b11, 8'h44, 8'h04);
    push(2'b00, 8'h55, 8'h05);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("stall_valid", out_valid, 1);
    chk("stall_result", out_result, 8'h11);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("order");
    stub_echo = 1'b0;

    // Core never answers: timeout after 64 WAIT cycles.
    stub_hang = 1'b1;
    exp_q.push_back('{res: 8'h80, zero: 1'b0, op: 2'b10, err: 1'b1});
    push(2'b10, 8'h33, 8'h44);
    drain("timeout");
    chk("timeout_latency", valid_cyc - start_cyc, 65);
    stub_hang = 1'b0;
    stub_res = 8'h5A; stub_zero = 1'b0; stub_delay = 3;
    s0 = n_starts;
    exp_q.push_back('{res: 8'h5A, zero: 1'b0, op: 2'b01, err: 1'b0});
    push(2'b01, 8'h10, 8'h20);
    drain("after_timeout");
    chk("after_timeout_starts", n_starts - s0, 1);

    // Reset during WAIT drops in-flight and queued work; late done ignored.
    stub_delay = 10;
    push(2'b00, 8'h01, 8'h02);
    push(2'b01, 8'h03, 8'h04);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    s0 = n_starts;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_wait_no_valid", seen, 0);
    chk("rst_wait_no_start", n_starts - s0, 0);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_in_ready", in_ready, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
